// File: rtl/demux1x2_7bits_hs.sv
// demux1x2_7bits_hs
// One-to-two demultiplexer with valid/ready handshakes on every side.
// Each output channel has a single-entry holding register.
// Routing is either by in_sel or by a round-robin pointer (auto_mode).
// Each channel keeps a wrapping count of the words it has delivered.

module demux1x2_7bits_hs #(
    parameter int WIDTH = 7,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             auto_mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic             next_ch
);

    typedef enum logic {EMPTY, FULL} slot_t;
    typedef enum logic {CH0, CH1} rr_t;

    slot_t slot0;
    slot_t slot1;
    rr_t   rr_ptr;

    logic in_xfer;
    logic in_to0;
    logic in_to1;
    logic out0_xfer;
    logic out1_xfer;

    // Target selection and input acceptance.
    // in_ready looks only at the targeted slot, so a stalled target blocks
    // the source even when the other channel has room.
    always_comb begin
        next_ch   = auto_mode ? (rr_ptr == CH1) : in_sel;
        in_ready  = next_ch ? ((slot1 == EMPTY) || out1_ready)
                            : ((slot0 == EMPTY) || out0_ready);
        in_xfer   = in_valid && in_ready;
        in_to0    = in_xfer && !next_ch;
        in_to1    = in_xfer && next_ch;
        out0_xfer = (slot0 == FULL) && out0_ready;
        out1_xfer = (slot1 == FULL) && out1_ready;
    end

    assign out0_valid = (slot0 == FULL);
    assign out1_valid = (slot1 == FULL);

    // Channel 0 holding register; a refill wins over a drain in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0     <= EMPTY;
            out0_data <= '0;
        end else if (in_to0) begin
            slot0     <= FULL;
            out0_data <= in_data;
        end else if (out0_xfer) begin
            slot0     <= EMPTY;
        end
    end

    // Channel 1 holding register; a refill wins over a drain in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot1     <= EMPTY;
            out1_data <= '0;
        end else if (in_to1) begin
            slot1     <= FULL;
            out1_data <= in_data;
        end else if (out1_xfer) begin
            slot1     <= EMPTY;
        end
    end

    // Delivered-word counters, wrapping silently at full scale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (out0_xfer) cnt0 <= cnt0 + CNT_W'(1);
            if (out1_xfer) cnt1 <= cnt1 + CNT_W'(1);
        end
    end

    // Round-robin pointer advances only on words accepted in auto mode and
    // keeps its value while routing manually.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= CH0;
        end else if (auto_mode && in_xfer) begin
            rr_ptr <= (rr_ptr == CH0) ? CH1 : CH0;
        end
    end

endmodule

// File: tb/tb_demux1x2_7bits_hs.sv
// tb_demux1x2_7bits_hs
// Directed testbench for demux1x2_7bits_hs with hand-computed expectations.
// Inputs change on the falling edge; registered outputs are sampled 1ns
// after the rising edge, combinational outputs just after the falling edge.

module tb_demux1x2_7bits_hs;

    logic       clk;
    logic       rst_n;
    logic       auto_mode;
    logic       in_valid;
    logic       in_ready;
    logic       in_sel;
    logic [6:0] in_data;
    logic       out0_valid;
    logic       out0_ready;
    logic [6:0] out0_data;
    logic       out1_valid;
    logic       out1_ready;
    logic [6:0] out1_data;
    logic [7:0] cnt0;
    logic [7:0] cnt1;
    logic       next_ch;

    int checks = 0;
    int errors = 0;

    demux1x2_7bits_hs #(.WIDTH(7), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .auto_mode(auto_mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
        .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
        .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data),
        .cnt0(cnt0), .cnt1(cnt1), .next_ch(next_ch)
    );

    // 10ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reset values and no transfer recorded while reset is held with in_valid=1
    task automatic test_reset();
        rst_n = 1'b0; auto_mode = 1'b1; in_valid = 1'b1; in_sel = 1'b1;
        in_data = 7'h3C; out0_ready = 1'b0; out1_ready = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        tick(); tick();
        checks++; if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b%b expected 00", out0_valid, out1_valid); end
        checks++; if (out0_data !== 7'h00 || out1_data !== 7'h00) begin errors++; $display("[TB] FAIL reset_data: got %h/%h expected 00/00", out0_data, out1_data); end
        checks++; if (cnt0 !== 8'd0 || cnt1 !== 8'd0) begin errors++; $display("[TB] FAIL reset_cnt: got %0d/%0d expected 0/0", cnt0, cnt1); end
        checks++; if (next_ch !== 1'b0) begin errors++; $display("[TB] FAIL reset_next_ch: got %b expected 0", next_ch); end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    // Manual routing to channel 1 with a stalled sink, then stability under stall
    task automatic test_route_stall();
        @(negedge clk);
        auto_mode = 1'b0; in_sel = 1'b1; in_data = 7'h5A; in_valid = 1'b1;
        out0_ready = 1'b0; out1_ready = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL route_in_ready_pre: got %b expected 1", in_ready); end
        checks++; if (out1_valid !== 1'b0) begin errors++; $display("[TB] FAIL route_no_passthru: got %b expected 0", out1_valid); end
        tick();
        checks++; if (out1_valid !== 1'b1 || out1_data !== 7'h5A) begin errors++; $display("[TB] FAIL route_out1: got %b/%h expected 1/5a", out1_valid, out1_data); end
        checks++; if (out0_valid !== 1'b0) begin errors++; $display("[TB] FAIL route_out0_idle: got %b expected 0", out0_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL route_stall_ready: got %b expected 0", in_ready); end
        @(negedge clk);
        in_data = 7'h7F;
        tick();
        checks++; if (out1_data !== 7'h5A || out1_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_hold: got %b/%h expected 1/5a", out1_valid, out1_data); end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Channel 1 stalled does not block a word aimed at empty channel 0
    task automatic test_other_channel();
        @(negedge clk);
        in_sel = 1'b0; in_data = 7'h11; in_valid = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL other_in_ready: got %b expected 1", in_ready); end
        tick();
        checks++; if (out0_valid !== 1'b1 || out0_data !== 7'h11) begin errors++; $display("[TB] FAIL other_out0: got %b/%h expected 1/11", out0_valid, out0_data); end
        checks++; if (out1_valid !== 1'b1 || out1_data !== 7'h5A) begin errors++; $display("[TB] FAIL other_out1_kept: got %b/%h expected 1/5a", out1_valid, out1_data); end
        @(negedge clk);
        in_valid = 1'b0; out0_ready = 1'b1; out1_ready = 1'b1;
        tick();
        checks++; if (cnt0 !== 8'd1 || cnt1 !== 8'd1) begin errors++; $display("[TB] FAIL dual_drain_cnt: got %0d/%0d expected 1/1", cnt0, cnt1); end
        checks++; if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin errors++; $display("[TB] FAIL dual_drain_valid: got %b%b expected 00", out0_valid, out1_valid); end
        @(negedge clk);
        out0_ready = 1'b0; out1_ready = 1'b0;
    endtask

    // Simultaneous drain and refill of channel 0
    task automatic test_simultaneous();
        @(negedge clk);
        in_sel = 1'b0; in_data = 7'h22; in_valid = 1'b1;
        tick();
        checks++; if (out0_data !== 7'h22) begin errors++; $display("[TB] FAIL simul_load: got %h expected 22", out0_data); end
        @(negedge clk);
        in_data = 7'h33; out0_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL simul_in_ready: got %b expected 1", in_ready); end
        tick();
        checks++; if (out0_valid !== 1'b1 || out0_data !== 7'h33) begin errors++; $display("[TB] FAIL simul_out0: got %b/%h expected 1/33", out0_valid, out0_data); end
        checks++; if (cnt0 !== 8'd2) begin errors++; $display("[TB] FAIL simul_cnt0: got %0d expected 2", cnt0); end
        @(negedge clk);
        in_valid = 1'b0;
        tick();
        checks++; if (out0_valid !== 1'b0 || cnt0 !== 8'd3) begin errors++; $display("[TB] FAIL simul_drain: got %b/%0d expected 0/3", out0_valid, cnt0); end
        @(negedge clk);
        out0_ready = 1'b0;
    endtask

    // Round robin over four words with both sinks always ready
    task automatic test_round_robin();
        logic [6:0] word;
        do_reset();
        auto_mode = 1'b1; in_sel = 1'b1; out0_ready = 1'b1; out1_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            word = 7'(i + 1);
            in_data = word; in_valid = 1'b1;
            tick();
            if (i % 2 == 0) begin
                checks++; if (out0_valid !== 1'b1 || out0_data !== word) begin errors++; $display("[TB] FAIL rr_word%0d: got ch0 %b/%h expected 1/%h", i + 1, out0_valid, out0_data, word); end
            end else begin
                checks++; if (out1_valid !== 1'b1 || out1_data !== word) begin errors++; $display("[TB] FAIL rr_word%0d: got ch1 %b/%h expected 1/%h", i + 1, out1_valid, out1_data, word); end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        tick();
        checks++; if (cnt0 !== 8'd2 || cnt1 !== 8'd2) begin errors++; $display("[TB] FAIL rr_cnt: got %0d/%0d expected 2/2", cnt0, cnt1); end
        checks++; if (next_ch !== 1'b0) begin errors++; $display("[TB] FAIL rr_next_ch: got %b expected 0", next_ch); end
    endtask

    // Pointer is preserved across mode switches; mode takes effect at once
    task automatic test_mode_switch();
        @(negedge clk);
        auto_mode = 1'b1; in_data = 7'h40; in_valid = 1'b1;
        tick();
        @(negedge clk);
        auto_mode = 1'b0; in_sel = 1'b0; in_data = 7'h41;
        #1;
        checks++; if (next_ch !== 1'b0) begin errors++; $display("[TB] FAIL mode_manual_next: got %b expected 0", next_ch); end
        tick();
        checks++; if (out0_data !== 7'h41 || cnt0 !== 8'd3) begin errors++; $display("[TB] FAIL mode_manual_word: got %h/%0d expected 41/3", out0_data, cnt0); end
        @(negedge clk);
        in_valid = 1'b0; auto_mode = 1'b1;
        #1;
        checks++; if (next_ch !== 1'b1) begin errors++; $display("[TB] FAIL mode_ptr_kept: got %b expected 1", next_ch); end
        tick();
        checks++; if (cnt0 !== 8'd4 || cnt1 !== 8'd2) begin errors++; $display("[TB] FAIL mode_cnt: got %0d/%0d expected 4/2", cnt0, cnt1); end
    endtask

    // 256 back-to-back channel-0 transfers wrap cnt0 to zero
    task automatic test_back_to_back_wrap();
        logic [6:0] word;
        do_reset();
        auto_mode = 1'b0; in_sel = 1'b0; out0_ready = 1'b1; out1_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            word = 7'(i);
            in_data = word;
            tick();
            checks++; if (out0_data !== word) begin errors++; $display("[TB] FAIL b2b_order%0d: got %h expected %h", i, out0_data, word); end
            @(negedge clk);
        end
        checks++; if (cnt0 !== 8'd255) begin errors++; $display("[TB] FAIL b2b_cnt255: got %0d expected 255", cnt0); end
        in_valid = 1'b0;
        tick();
        checks++; if (cnt0 !== 8'd0 || cnt1 !== 8'd0) begin errors++; $display("[TB] FAIL wrap_cnt: got %0d/%0d expected 0/0", cnt0, cnt1); end
        @(negedge clk);
        out0_ready = 1'b0;
    endtask

    // Reset mid-cycle with both channels full and pointer at CH1
    task automatic test_reset_mid();
        auto_mode = 1'b0; in_sel = 1'b1; in_data = 7'h01; in_valid = 1'b1; out1_ready = 1'b1;
        tick();
        @(negedge clk);
        in_valid = 1'b0;
        tick();
        @(negedge clk);
        out1_ready = 1'b0; in_data = 7'h0A; in_valid = 1'b1;
        tick();
        @(negedge clk);
        auto_mode = 1'b1; in_data = 7'h0B;
        tick();
        checks++; if (out0_valid !== 1'b1 || out1_valid !== 1'b1 || next_ch !== 1'b1 || cnt1 !== 8'd1) begin
            errors++; $display("[TB] FAIL pre_reset_state: got v=%b%b next=%b cnt1=%0d expected 11/1/1", out0_valid, out1_valid, next_ch, cnt1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_valid: got %b%b expected 00", out0_valid, out1_valid); end
        checks++; if (out0_data !== 7'h00 || out1_data !== 7'h00) begin errors++; $display("[TB] FAIL mid_reset_data: got %h/%h expected 00/00", out0_data, out1_data); end
        checks++; if (cnt0 !== 8'd0 || cnt1 !== 8'd0) begin errors++; $display("[TB] FAIL mid_reset_cnt: got %0d/%0d expected 0/0", cnt0, cnt1); end
        checks++; if (next_ch !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_reset_ptr: got next=%b rdy=%b expected 0/1", next_ch, in_ready); end
        @(negedge clk);
        rst_n = 1'b1; in_data = 7'h55; in_valid = 1'b1;
        tick();
        checks++; if (out0_valid !== 1'b1 || out0_data !== 7'h55 || out1_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL post_reset_word: got v=%b%b d0=%h expected 10/55", out0_valid, out1_valid, out0_data);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_route_stall();
        test_other_channel();
        test_simultaneous();
        test_round_robin();
        test_mode_switch();
        test_back_to_back_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux1x2_7bits_hs.md
DEMUX1X2_7BITS_HS -- requirements
Module: demux1x2_7bits_hs

Interface
REQ-001 The block SHALL have parameter WIDTH, default 7, giving the data width in bits.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the width of each per-channel transfer counter.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 auto_mode  input  1  0: route by in_sel; 1: alternate channels round-robin and ignore in_sel.
REQ-006 in_valid  input  1  source offers a word.
REQ-007 in_ready  output  1  block accepts the word this cycle.
REQ-008 in_sel  input  1  target channel when auto_mode=0 (0 = channel 0, 1 = channel 1).
REQ-009 in_data  input  WIDTH  word offered.
REQ-010 out0_valid, out1_valid  output  1 each  channel holds a word.
REQ-011 out0_ready, out1_ready  input  1 each  sink takes the word this cycle.
REQ-012 out0_data, out1_data  output  WIDTH each  registered channel word.
REQ-013 cnt0, cnt1  output  CNT_W each  count of words delivered on each channel.
REQ-014 next_ch  output  1  channel the next accepted word goes to; equals in_sel when auto_mode=0, else the round-robin pointer.

Function
REQ-015 Input transfer SHALL occur when in_valid=1 and in_ready=1 at a rising edge. Output transfer on channel k SHALL occur when outk_valid=1 and outk_ready=1.
REQ-016 Each channel SHALL have a one-entry holding register with states EMPTY and FULL. outk_valid=1 exactly in FULL.
REQ-017 EMPTY->FULL on an input transfer targeting k. FULL->EMPTY on an output transfer with no input transfer to k. FULL->FULL with new data on simultaneous output and input transfer to k.
REQ-018 in_ready SHALL be combinational: 1 iff the target channel (next_ch) is EMPTY or its outk_ready=1 this cycle. It SHALL NOT depend on in_valid.
REQ-019 Latency: a word accepted at edge N SHALL appear on outk_data with outk_valid=1 after edge N; it SHALL NOT pass through combinationally.
REQ-020 outk_data SHALL hold stable while outk_valid=1 and outk_ready=0; the non-target channel SHALL be unaffected by an input transfer.
REQ-021 Round-robin pointer states CH0 and CH1: reset to CH0; toggle only on an input transfer while auto_mode=1; hold otherwise.
REQ-022 A change of auto_mode SHALL take effect in the same cycle. The pointer SHALL keep its value across mode changes.
REQ-023 cntk SHALL increment by 1 on each output transfer of channel k and wrap from 2^CNT_W-1 to 0 with no flag.
REQ-024 Both channels MAY transfer out in the same cycle. Counters SHALL update independently.
REQ-025 When the target channel is FULL with outk_ready=0, the input SHALL stall (in_ready=0), even if the other channel is EMPTY.
REQ-026 No word SHALL be dropped or duplicated. Words SHALL leave each channel in acceptance order.

Reset
REQ-027 While rst_n=0, asynchronously: both channels EMPTY; out0_valid=out1_valid=0; out0_data=out1_data=0; cnt0=cnt1=0; pointer=CH0.
REQ-028 Reset asserted mid-operation SHALL discard held words. The first accepted word after release SHALL go to channel 0 when auto_mode=1.
REQ-029 in_ready SHALL be 1 during reset (both channels EMPTY); no transfer SHALL be recorded while rst_n=0.

Verification
REQ-030 auto_mode=0, in_sel=1, in_data=7'h5A, out1_ready=0 -> next cycle out1_valid=1, out1_data=7'h5A, out0_valid=0, in_ready=0 while in_sel=1.
REQ-031 Channel 1 FULL and stalled, in_sel=0, in_data=7'h11 -> in_ready=1; next cycle out0_data=7'h11, channel 1 unchanged.
REQ-032 auto_mode=1, four words 1,2,3,4, both sinks always ready -> channel 0 gets 1,3; channel 1 gets 2,4; cnt0=cnt1=2; next_ch=0.
REQ-033 Channel 0 FULL (7'h22), out0_ready=1 and a new input 7'h33 to channel 0 in the same cycle -> in_ready=1; next cycle out0_data=7'h33, out0_valid=1, cnt0 +1.
REQ-034 Run 256 channel-0 transfers with CNT_W=8 -> cnt0 wraps to 0; cnt1 unchanged.
REQ-035 Assert rst_n=0 mid-cycle with both channels FULL and pointer=CH1 -> immediately valids=0, data=0, counters=0; after release next_ch=0 in auto_mode.
